// File: rtl/traffic_pkg.sv
// Shared state codes, mode encodings and lamp patterns for the two-group
// traffic phase controller.
package traffic_pkg;

    typedef enum logic [3:0] {
        NIGHT    = 4'd0,
        ALLRED_A = 4'd1,
        G1       = 4'd2,
        Y1       = 4'd3,
        G1L      = 4'd4,
        Y1L      = 4'd5,
        ALLRED_B = 4'd6,
        G2       = 4'd7,
        Y2       = 4'd8,
        G2L      = 4'd9,
        Y2L      = 4'd10,
        EMG1     = 4'd11,
        EMG2     = 4'd12
    } state_e;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;

    // Bit order {R1,Y1,G1,R1L,Y1L,G1L,R2,Y2,G2,R2L,Y2L,G2L}.
    localparam logic [11:0] LAMP_ALLRED  = 12'b100_100_100_100;
    localparam logic [11:0] LAMP_G1      = 12'b001_100_100_100;
    localparam logic [11:0] LAMP_Y1      = 12'b010_100_100_100;
    localparam logic [11:0] LAMP_G1L     = 12'b100_001_100_100;
    localparam logic [11:0] LAMP_Y1L     = 12'b100_010_100_100;
    localparam logic [11:0] LAMP_G2      = 12'b100_100_001_100;
    localparam logic [11:0] LAMP_Y2      = 12'b100_100_010_100;
    localparam logic [11:0] LAMP_G2L     = 12'b100_100_100_001;
    localparam logic [11:0] LAMP_Y2L     = 12'b100_100_100_010;
    localparam logic [11:0] LAMP_NIGHT_Y = 12'b010_010_010_010;
    localparam logic [11:0] LAMP_OFF     = 12'b000_000_000_000;

    function automatic logic [11:0] lamp_of(state_e s);
        case (s)
            G1, EMG1: lamp_of = LAMP_G1;
            Y1:       lamp_of = LAMP_Y1;
            G1L:      lamp_of = LAMP_G1L;
            Y1L:      lamp_of = LAMP_Y1L;
            G2, EMG2: lamp_of = LAMP_G2;
            Y2:       lamp_of = LAMP_Y2;
            G2L:      lamp_of = LAMP_G2L;
            Y2L:      lamp_of = LAMP_Y2L;
            NIGHT:    lamp_of = LAMP_OFF;
            default:  lamp_of = LAMP_ALLRED;
        endcase
    endfunction

    function automatic logic is_green(state_e s);
        is_green = (s == G1) || (s == G1L) || (s == G2) || (s == G2L);
    endfunction

    function automatic state_e yellow_of(state_e s);
        case (s)
            G1:      yellow_of = Y1;
            G1L:     yellow_of = Y1L;
            G2:      yellow_of = Y2;
            G2L:     yellow_of = Y2L;
            default: yellow_of = s;
        endcase
    endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Settings, requests and lamp/display outputs of the phase scheduler.
interface phase_scheduler_if #(
    parameter int CNT_WIDTH = 11
);
    logic                 tick_1s;
    logic [1:0]           mode;
    logic [CNT_WIDTH-1:0] green_len;
    logic [CNT_WIDTH-1:0] yellow_len;
    logic [1:0]           ped_req;
    logic [1:0]           emg_req;
    logic [11:0]          lamps;
    logic [CNT_WIDTH-1:0] remain;
    logic [3:0]           phase;
    logic [1:0]           ped_pend;

    // No handshake: tick_1s and ped_req are single-cycle strobes, emg_req is a
    // level, the rest are static settings; outputs are registered levels.
    modport master (
        output tick_1s, mode, green_len, yellow_len, ped_req, emg_req,
        input  lamps, remain, phase, ped_pend
    );

    modport slave (
        input  tick_1s, mode, green_len, yellow_len, ped_req, emg_req,
        output lamps, remain, phase, ped_pend
    );
endinterface

// File: rtl/phase_timer.sv
// Remaining-time counter: loads a phase length (0 treated as 1), counts down
// on ticks and flags the final tick of a phase.
module phase_timer #(
    parameter int W       = 11,
    parameter int RST_VAL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    input  logic         tick,
    input  logic         en,
    output logic [W-1:0] remain,
    output logic         last
);
    localparam logic [W-1:0] RST_V = (RST_VAL == 0) ? W'(1) : W'(RST_VAL);

    logic [W-1:0] remain_q, remain_d;

    always_comb begin
        remain_d = remain_q;
        if (clr) begin
            remain_d = '0;
        end else if (load) begin
            remain_d = (load_val == '0) ? W'(1) : load_val;
        end else if (en && tick && remain_q > W'(1)) begin
            remain_d = remain_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) remain_q <= RST_V;
        else     remain_q <= remain_d;
    end

    assign remain = remain_q;
    assign last   = (remain_q == W'(1));

endmodule

// File: rtl/phase_scheduler.sv
// Two-group intersection phase controller with all-red clearance, pedestrian
// green shortening, emergency preemption, night flash and settings hold.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_WIDTH  = 11,
    parameter int ALLRED_LEN = 1,
    parameter int PED_MIN    = 3
) (
    input logic              clk,
    input logic              rst,
    phase_scheduler_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] ALLRED_V  = CNT_WIDTH'(ALLRED_LEN);
    localparam logic [CNT_WIDTH-1:0] PED_MIN_V = CNT_WIDTH'(PED_MIN);

    state_e               state_q, state_d, nxt;
    logic [11:0]          lamps_q, lamps_d;
    logic [1:0]           ped_pend_q, ped_pend_d;
    logic                 emg_pend_q, emg_pend_d, emg_grp_q, emg_grp_d;
    logic                 go, run_mode, emg_sel, emg_trig, pend_now, grp_now, shorten;
    logic                 t_load, t_clr, t_en, t_last;
    logic [CNT_WIDTH-1:0] t_val, remain;

    function automatic state_e succ(state_e s, logic pend, logic grp);
        case (s)
            ALLRED_A: succ = pend ? (grp ? EMG2 : EMG1) : G1;
            G1:       succ = Y1;
            Y1:       succ = pend ? ALLRED_B : G1L;
            G1L:      succ = Y1L;
            Y1L:      succ = ALLRED_B;
            ALLRED_B: succ = pend ? (grp ? EMG2 : EMG1) : G2;
            G2:       succ = Y2;
            Y2:       succ = pend ? ALLRED_A : G2L;
            G2L:      succ = Y2L;
            default:  succ = ALLRED_A;
        endcase
    endfunction

    always_comb begin
        run_mode = (bus.mode == MODE_RUN);
        emg_sel  = ~bus.emg_req[0];
        // A request for group g never cuts short a green already serving g.
        emg_trig = run_mode && (state_q != NIGHT) && (state_q != EMG1) && (state_q != EMG2)
                   && (bus.emg_req != 2'b00)
                   && !(emg_sel ? (state_q == G2 || state_q == G2L)
                                : (state_q == G1 || state_q == G1L));
        pend_now = emg_pend_q | emg_trig;
        grp_now  = emg_trig ? emg_sel : emg_grp_q;
        shorten  = ((state_q == G1 && ped_pend_q[1]) || (state_q == G2 && ped_pend_q[0]))
                   && (remain > PED_MIN_V);

        go         = 1'b0;
        nxt        = state_q;
        t_load     = 1'b0;
        t_clr      = 1'b0;
        t_en       = 1'b0;
        t_val      = '0;
        state_d    = state_q;
        lamps_d    = lamps_q;
        ped_pend_d = ped_pend_q | bus.ped_req;
        emg_pend_d = pend_now;
        emg_grp_d  = grp_now;

        if ((bus.mode & MODE_HOLD) == 2'b00) begin
            if (bus.mode == MODE_NIGHT) begin
                emg_pend_d = 1'b0;
                if (state_q != NIGHT) begin
                    state_d = NIGHT;
                    lamps_d = LAMP_OFF;
                    t_clr   = 1'b1;
                end else if (bus.tick_1s) begin
                    lamps_d = lamps_q ^ LAMP_NIGHT_Y;
                end
            end else if (state_q == NIGHT) begin
                go  = 1'b1;
                nxt = ALLRED_A;
            end else if (state_q == EMG1 || state_q == EMG2) begin
                if (!bus.emg_req[state_q == EMG2]) begin
                    go  = 1'b1;
                    nxt = (state_q == EMG2) ? Y2 : Y1;
                end
            end else if (emg_trig && is_green(state_q)) begin
                go  = 1'b1;
                nxt = yellow_of(state_q);
            end else if (shorten) begin
                t_load = 1'b1;
                t_val  = PED_MIN_V;
            end else if (bus.tick_1s && t_last) begin
                go  = 1'b1;
                nxt = succ(state_q, pend_now, grp_now);
            end else begin
                t_en = 1'b1;
            end
        end

        // Every phase entry samples its length and applies entry side effects.
        if (go) begin
            state_d = nxt;
            lamps_d = lamp_of(nxt);
            case (nxt)
                G1, G1L, G2, G2L:   begin t_load = 1'b1; t_val = bus.green_len;  end
                Y1, Y1L, Y2, Y2L:   begin t_load = 1'b1; t_val = bus.yellow_len; end
                ALLRED_A, ALLRED_B: begin t_load = 1'b1; t_val = ALLRED_V;       end
                default:            t_clr = 1'b1;
            endcase
            if (nxt == Y1) ped_pend_d[1] = 1'b0;
            if (nxt == Y2) ped_pend_d[0] = 1'b0;
            if (nxt == EMG1 || nxt == EMG2) emg_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ALLRED_A;
            lamps_q    <= LAMP_ALLRED;
            ped_pend_q <= 2'b00;
            emg_pend_q <= 1'b0;
            emg_grp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lamps_q    <= lamps_d;
            ped_pend_q <= ped_pend_d;
            emg_pend_q <= emg_pend_d;
            emg_grp_q  <= emg_grp_d;
        end
    end

    phase_timer #(
        .W       (CNT_WIDTH),
        .RST_VAL (ALLRED_LEN)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .clr      (t_clr),
        .tick     (bus.tick_1s),
        .en       (t_en),
        .remain   (remain),
        .last     (t_last)
    );

    assign bus.lamps    = lamps_q;
    assign bus.remain   = remain;
    assign bus.phase    = state_q;
    assign bus.ped_pend = ped_pend_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: a phase-table model predicts every
// output each cycle, plus hand-computed checkpoints for the key scenarios.
module tb_phase_scheduler;
    localparam int W = 11;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [28:0] exp_q[$];

    phase_scheduler_if #(.CNT_WIDTH(W)) bus ();

    phase_scheduler #(.CNT_WIDTH(W), .ALLRED_LEN(1), .PED_MIN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Phases 1..10 form two five-step groups: kind 0 all-red, 1 through green,
    // 2 through yellow, 3 left green, 4 left yellow. 11/12 are emergency greens.
    int          m_phase, m_remain, m_grp;
    logic [11:0] m_lamps;
    logic [1:0]  m_ped;
    bit          m_pend, m_valid = 1'b0;

    function automatic int kind_of(int p);
        return (p <= 5) ? p - 1 : p - 6;
    endfunction

    function automatic int grp_of(int p);
        return (p >= 6) ? 1 : 0;
    endfunction

    function automatic logic [11:0] head_lamp(int head, int color);
        logic [11:0] l;
        int base;
        l = 12'b100_100_100_100;
        base = 11 - 3 * head;
        l[base] = 1'b0;
        l[base - color] = 1'b1;
        return l;
    endfunction

    function automatic logic [11:0] lamp_for(int p);
        int k;
        if (p == 0) return 12'd0;
        if (p >= 11) return head_lamp(2 * (p - 11), 2);
        k = kind_of(p);
        if (k == 0) return 12'b100_100_100_100;
        return head_lamp(2 * grp_of(p) + ((k >= 3) ? 1 : 0), (k % 2 == 1) ? 2 : 1);
    endfunction

    function automatic int len_for(int p);
        int k, v;
        if (p == 0 || p >= 11) return 0;
        k = kind_of(p);
        if (k == 0) return 1;
        v = (k % 2 == 1) ? int'(bus.green_len) : int'(bus.yellow_len);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic enter(int n);
        m_phase  = n;
        m_lamps  = lamp_for(n);
        m_remain = len_for(n);
        if (n == 3) m_ped[1] = 1'b0;
        if (n == 8) m_ped[0] = 1'b0;
        if (n >= 11) m_pend = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] old_ped;
        int sel, k, g;
        bit trig;
        if (rst) begin
            m_phase = 1; m_remain = 1; m_lamps = lamp_for(1);
            m_ped = 2'b00; m_pend = 1'b0; m_grp = 0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        old_ped = m_ped;
        m_ped = m_ped | bus.ped_req;
        if (bus.mode[1]) return;
        if (bus.mode == 2'b01) begin
            m_pend = 1'b0;
            if (m_phase != 0) begin
                m_phase = 0; m_remain = 0; m_lamps = 12'd0;
            end else if (bus.tick_1s) begin
                m_lamps = m_lamps ^ 12'b010_010_010_010;
            end
            return;
        end
        sel  = bus.emg_req[0] ? 0 : 1;
        k    = kind_of(m_phase);
        g    = grp_of(m_phase);
        trig = (m_phase >= 1 && m_phase <= 10) && (bus.emg_req != 2'b00)
               && !((k == 1 || k == 3) && g == sel);
        if (trig) begin m_pend = 1'b1; m_grp = sel; end
        if (m_phase == 0) enter(1);
        else if (m_phase >= 11) begin
            if (!bus.emg_req[m_phase - 11]) enter((m_phase == 11) ? 3 : 8);
        end
        else if (trig && (k % 2 == 1)) enter(m_phase + 1);
        else if (k == 1 && old_ped[1 - g] && m_remain > 3) m_remain = 3;
        else if (bus.tick_1s) begin
            if (m_remain == 1) begin
                if (k == 0 && m_pend) enter(11 + m_grp);
                else if (k == 2 && m_pend) enter((g == 1) ? 1 : 6);
                else enter((m_phase == 10) ? 1 : m_phase + 1);
            end else begin
                m_remain = m_remain - 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        if (m_valid) exp_q.push_back({4'(m_phase), 11'(m_remain), m_lamps, m_ped});
    end

    always @(negedge clk) begin
        logic [28:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_phase", int'(bus.phase), int'(e[28:25]));
            check("sb_remain", int'(bus.remain), int'(e[24:14]));
            check("sb_lamps", int'(bus.lamps), int'(e[13:2]));
            check("sb_ped_pend", int'(bus.ped_pend), int'(e[1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            bus.tick_1s = 1'b1;
            @(negedge clk);
            bus.tick_1s = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic tick_until(input int target, input string name, output int n);
        n = 0;
        while (int'(bus.phase) != target && n < 150) begin
            tick(1);
            n++;
        end
        check(name, int'(bus.phase), target);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        bus.tick_1s = 1'b0; bus.mode = 2'b00; bus.green_len = 11'd8; bus.yellow_len = 11'd6;
        bus.ped_req = 2'b00; bus.emg_req = 2'b00;
        rst = 1'b1;
        cycles(3);
        check("rst_phase", int'(bus.phase), 1);
        check("rst_remain", int'(bus.remain), 1);
        check("rst_lamps", int'(bus.lamps), 12'h924);
        check("rst_ped", int'(bus.ped_pend), 0);
        rst = 1'b0;
        cycles(1);

        // Full run cycle: ALLRED 1 tick, G1 8..1, whole cycle 58 ticks.
        tick(1);
        check("g1_entry_phase", int'(bus.phase), 2);
        check("g1_entry_remain", int'(bus.remain), 8);
        check("g1_lamps", int'(bus.lamps), 12'h324);
        tick(7);
        check("g1_last_remain", int'(bus.remain), 1);
        tick_until(1, "cycle_wrap", n);
        check("cycle_ticks", 1 + 7 + n, 58);

        // Pedestrian shortening of G1.
        tick(2);
        check("g1_remain7", int'(bus.remain), 7);
        bus.ped_req = 2'b10; @(negedge clk); bus.ped_req = 2'b00; @(negedge clk);
        check("ped_short_remain", int'(bus.remain), 3);
        check("ped_pend_set", int'(bus.ped_pend), 2);
        tick(3);
        check("ped_y1_phase", int'(bus.phase), 3);
        check("ped_y1_clear", int'(bus.ped_pend), 0);
        check("ped_y1_remain", int'(bus.remain), 6);

        // Emergency for group 2 raised during G1.
        tick_until(2, "reach_g1", n);
        bus.emg_req = 2'b10; @(negedge clk);
        check("emg_trunc_phase", int'(bus.phase), 3);
        check("emg_trunc_remain", int'(bus.remain), 6);
        tick(6);
        check("emg_allred_b", int'(bus.phase), 6);
        tick(1);
        check("emg2_phase", int'(bus.phase), 12);
        check("emg2_remain", int'(bus.remain), 0);
        check("emg2_lamps", int'(bus.lamps), 12'h90c);
        tick(3);
        check("emg2_hold", int'(bus.phase), 12);
        bus.emg_req = 2'b00; @(negedge clk);
        check("emg_rel_y2", int'(bus.phase), 8);
        check("emg_rel_remain", int'(bus.remain), 6);
        tick(5);
        check("y2_still", int'(bus.phase), 8);
        tick(1);
        check("y2_done", int'(bus.phase), 9);

        // Night mode from G2.
        tick_until(7, "reach_g2", n);
        bus.mode = 2'b01; @(negedge clk);
        check("night_phase", int'(bus.phase), 0);
        check("night_remain", int'(bus.remain), 0);
        check("night_lamps0", int'(bus.lamps), 0);
        tick(1);
        check("night_lamps1", int'(bus.lamps), 12'h492);
        tick(1);
        check("night_lamps2", int'(bus.lamps), 0);
        bus.mode = 2'b00; @(negedge clk);
        check("night_exit", int'(bus.phase), 1);

        // Hold freezes timing; new green_len applies at next green entry.
        tick_until(2, "reach_g1_b", n);
        tick(4);
        check("hold_pre", int'(bus.remain), 4);
        bus.mode = 2'b10;
        bus.ped_req = 2'b01; @(negedge clk); bus.ped_req = 2'b00;
        tick(5);
        check("hold_remain", int'(bus.remain), 4);
        check("hold_phase", int'(bus.phase), 2);
        check("hold_ped", int'(bus.ped_pend), 1);
        bus.green_len = 11'd3;
        bus.mode = 2'b00; @(negedge clk);
        tick_until(4, "reach_g1l", n);
        check("new_green_len", int'(bus.remain), 3);

        // Zero-length green lasts one tick; Y2 entry clears ped_pend[0].
        bus.green_len = 11'd0;
        tick_until(7, "reach_g2_zero", n);
        check("zero_green_remain", int'(bus.remain), 1);
        tick(1);
        check("zero_green_y2", int'(bus.phase), 8);
        check("y2_ped_clear", int'(bus.ped_pend), 0);

        // Reset during Y2.
        tick(2);
        rst = 1'b1; @(negedge clk);
        check("mid_rst_phase", int'(bus.phase), 1);
        check("mid_rst_lamps", int'(bus.lamps), 12'h924);
        check("mid_rst_remain", int'(bus.remain), 1);
        rst = 1'b0;

        // Both emergency bits: group 1 (bit 0) wins, then group 2 follows.
        bus.green_len = 11'd8;
        tick_until(7, "reach_g2_emg", n);
        bus.emg_req = 2'b11; @(negedge clk);
        check("emg_both_trunc", int'(bus.phase), 8);
        tick_until(11, "emg1_reached", n);
        bus.emg_req = 2'b10; @(negedge clk);
        check("emg1_rel_y1", int'(bus.phase), 3);
        tick_until(12, "emg2_after_emg1", n);
        bus.emg_req = 2'b00;
        cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Intersection phase controller for the two-group traffic light. It sequences the through and left-turn phases of both groups from a 1 s tick and drives the 12 lamp outputs and the remaining-time count for the seven-segment path. It adds all-red clearance, latched pedestrian requests that shorten the conflicting green, and level-held emergency preemption. It replaces ad-hoc state logic in the top level and feeds the lamp shift register and display converters unchanged.

## Interface
- CNT_WIDTH, 11, width of all duration and count values
- ALLRED_LEN, 1, all-red clearance duration, in ticks
- PED_MIN, 3, green remaining after a pedestrian request is honoured, in ticks
- clk  in  1  system clock (12 MHz)
- rst  in  1  reset: synchronous, active-high
- tick_1s  in  1  one-cycle pulse, once per second
- mode  in  2  00 run, 01 night, 1x hold (settings being edited)
- green_len  in  CNT_WIDTH  duration of through and left-turn greens
- yellow_len  in  CNT_WIDTH  duration of yellows
- ped_req  in  2  one-cycle pulse per group; bit g requests the crossing of group g
- emg_req  in  2  level; bit g requests green for group g
- lamps  out  12  {R1,Y1,G1,R1L,Y1L,G1L,R2,Y2,G2,R2L,Y2L,G2L}
- remain  out  CNT_WIDTH  ticks left in the current phase
- phase  out  4  current state code
- ped_pend  out  2  latched pedestrian requests

## Operation
- Run sequence: ALLRED_A → G1 → Y1 → G1L → Y1L → ALLRED_B → G2 → Y2 → G2L → Y2L → ALLRED_A.
- Extra states: NIGHT and EMG.
- Lamp patterns:
  - Gx: Gx=1, all other heads red.
  - Yx: Yx=1, all other heads red.
  - GxL / YxL: the left-turn head is G or Y, all other heads red.
  - ALLRED: 100_100_100_100.
  - EMG for group g: Gg=1, all other heads red.
- Phase entry loads `remain`:
  - greens load green_len.
  - yellows load yellow_len.
  - ALLRED loads ALLRED_LEN.
  - A length of 0 is treated as 1.
  - Lengths are sampled only at entry. Edits made mid-phase affect the next entry only.
- On tick_1s in run mode:
  - If remain == 1, advance to the next state and load its length.
  - Otherwise, decrement remain.
- Pedestrian requests:
  - ped_req[g] sets ped_pend[g].
  - ped_pend[g] is cleared on entry to Y(1-g).
  - While in G(1-g) with ped_pend[g]=1 and remain > PED_MIN, remain is set to PED_MIN on the next cycle, applied once.
- Emergency preemption (run mode only):
  - If emg_req[g] is asserted and the state is not already EMG(g) and not in a group-g green, the controller truncates:
    - A green state jumps to its own yellow. The yellow, then ALLRED, still run.
    - After that ALLRED, the next state is EMG(g) instead of the normal successor.
  - EMG(g) holds with remain = 0 while emg_req[g]=1. On release the controller enters Yg.
  - Priority: if both bits are set, bit 0 wins.
- Night mode (mode 01):
  - From any state, the controller enters NIGHT on the next cycle with remain = 0.
  - Y1/Y2/Y1L/Y2L toggle on each tick. All other lamps are 0.
  - Leaving NIGHT enters ALLRED_A.
- Hold mode (mode 1x):
  - State, remain and lamps are frozen. Ticks are ignored.
  - ped_pend still latches.
  - Emergency requests are ignored.

## Timing
- Reset values:
  - State ALLRED_A, remain = ALLRED_LEN.
  - lamps = 100_100_100_100.
  - ped_pend = 0.
  - phase = ALLRED_A code.
- All outputs are registered. lamps, remain and phase change on the same edge, one cycle after the tick or mode change that causes them.
- Simultaneous events, same cycle:
  - mode change beats tick.
  - Emergency truncation beats the pedestrian shorten.
  - A ped_req arriving with the clearing Y entry leaves ped_pend clear.
- rst asserted mid-phase returns to the reset state on the next edge, regardless of mode.
- A G→Y transition caused by emg_req takes one cycle and does not wait for a tick.

## Structure
- Package traffic_pkg holds:
  - State enum codes: NIGHT=0, ALLRED_A=1, G1, Y1, G1L, Y1L, ALLRED_B, G2, Y2, G2L, Y2L, EMG1, EMG2.
  - The 12-bit lamp pattern constants.
  - The mode encodings.
- Sub-module phase_timer: a load/decrement counter with inputs load, load_val, tick, en, and outputs remain and last (remain == 1). It includes the clamp of 0 to 1.

## Test plan
- Reset, run, green_len=8, yellow_len=6, 1 s ticks:
  - ALLRED lasts 1 tick.
  - G1 lasts 8 ticks, with remain going 8→1.
  - The full cycle is 2×(8+6+8+6+1) = 58 ticks.
- ped_req[1] at G1 with remain=7: remain=3 on the next cycle. Y1 follows after 3 ticks, and ped_pend[1] clears there.
- emg_req[1] raised during G1: next cycle Y1 (remain=6), then ALLRED_B, then EMG2 held. Release it: Y2 for 6 ticks.
- mode=01 during G2: NIGHT next cycle, yellows toggle per tick. mode=00: ALLRED_A.
- mode=10 with remain=4 and 5 ticks applied: remain stays 4. Change green_len to 3 and resume: the next G entry loads 3.
- green_len=0: greens last 1 tick. rst during Y2: next cycle lamps=100_100_100_100, remain=1.
